// File: rtl/alu_cmd_driver.sv
// Valid/ready command driver for a handshake-less combinational ALU: launches operands,
// waits SETTLE cycles, captures the result and holds it on a response port. Optional
// golden-model self-check is enabled by defining ALU_DRV_CHECK_EN.
module alu_cmd_driver #(
    parameter int WIDTH  = 5,
    parameter int SETTLE = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [1:0]       req_op,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [1:0]       alu_sel,
    input  logic [WIDTH-1:0] alu_out,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic [1:0]       rsp_op,
    output logic             busy,
    output logic [7:0]       op_count,
    output logic             mismatch
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [3:0] CNT_INIT = 4'(SETTLE - 1);

    state_t     state;
    logic [3:0] cnt;
    logic       capture;

    // In RESP the slot frees on the same edge the response is taken, so a new
    // request can be accepted without an idle bubble.
    assign req_ready = (state == IDLE) || ((state == RESP) && rsp_ready);
    assign busy      = (state != IDLE);
    assign capture   = (state == WAIT) && (cnt == 4'd0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            alu_a     <= '0;
            alu_b     <= '0;
            alu_sel   <= 2'b00;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_op    <= 2'b00;
            op_count  <= 8'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        alu_a   <= req_a;
                        alu_b   <= req_b;
                        alu_sel <= req_op;
                        cnt     <= CNT_INIT;
                        state   <= WAIT;
                    end
                end
                WAIT: begin
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        rsp_data  <= alu_out;
                        rsp_op    <= alu_sel;
                        rsp_valid <= 1'b1;
                        state     <= RESP;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        op_count  <= op_count + 8'd1;
                        rsp_valid <= 1'b0;
                        if (req_valid) begin
                            alu_a   <= req_a;
                            alu_b   <= req_b;
                            alu_sel <= req_op;
                            cnt     <= CNT_INIT;
                            state   <= WAIT;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef ALU_DRV_CHECK_EN
    logic [WIDTH-1:0] model_out;

    always_comb begin
        model_out = '0;
        case (alu_sel)
            2'b00:   model_out = alu_a & alu_b;
            2'b01:   model_out = alu_a + alu_b;
            2'b10:   model_out = alu_a | alu_b;
            default: model_out = alu_a ^ alu_b;
        endcase
    end

    // Sticky until reset so a single transient ALU fault is never lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mismatch <= 1'b0;
        end else if (capture && (alu_out != model_out)) begin
            mismatch <= 1'b1;
        end
    end
`else
    logic unused_capture;
    assign unused_capture = capture;
    assign mismatch       = 1'b0;
`endif

endmodule
